// File: rtl/mem2_load_unit_if.sv
// MEM2 load-unit bus: pipeline controls, load attributes,
// read response and formatted results.
interface mem2_load_unit_if;
  logic        MEM2_Flush;
  logic        WB_Wr;
  logic        MEM_Valid;
  logic        MEM_IsLoad;
  logic [2:0]  MEM_LoadType;
  logic [1:0]  MEM_AddrLo;
  logic [31:0] MEM_OutB;
  logic [31:0] MEM_ALUOut;
  logic [31:0] MEM_PC;
  logic [1:0]  MEM_WbSel;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] MEM2_DMOut;
  logic [31:0] MEM2_Result;
  logic        MEM2_Stall;
  logic        timeout_err;

  modport master (
    output MEM2_Flush, WB_Wr,
    output MEM_Valid, MEM_IsLoad,
    output MEM_LoadType, MEM_AddrLo,
    output MEM_OutB, MEM_ALUOut,
    output MEM_PC, MEM_WbSel,
    output rsp_valid, rsp_data,
    input  MEM2_DMOut, MEM2_Result,
    input  MEM2_Stall, timeout_err
  );

  modport slave (
    input  MEM2_Flush, WB_Wr,
    input  MEM_Valid, MEM_IsLoad,
    input  MEM_LoadType, MEM_AddrLo,
    input  MEM_OutB, MEM_ALUOut,
    input  MEM_PC, MEM_WbSel,
    input  rsp_valid, rsp_data,
    output MEM2_DMOut, MEM2_Result,
    output MEM2_Stall, timeout_err
  );
endinterface

// File: rtl/mem2_load_unit.sv
// MEM2 load unit: waits for load data, formats it, picks the
// write-back value. Optional LWL/LWR merge under `LWLR_EN.
module mem2_load_unit #(
  parameter int RSP_TIMEOUT = 1024,
  parameter int CNT_W       = 11
) (
  input logic              clk,
  input logic              rst,
  mem2_load_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(RSP_TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      buf_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_q;
  logic             cnt_run;
  logic             cap;
  logic             is_load;
  logic [31:0]      d;
  logic [1:0]       a;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      fmt_data;
  logic [31:0]      dm;
  logic             stall;

  assign is_load = bus.MEM_Valid & bus.MEM_IsLoad;
  assign d       = bus.rsp_data;
  assign a       = bus.MEM_AddrLo;
  assign cnt_inc = cnt + 1'b1;

  assign byte_sel = d[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? d[31:16] : d[15:0];

  always_comb begin
    fmt_data = d;
    case (bus.MEM_LoadType)
      3'b001:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'b010:  fmt_data = {24'd0, byte_sel};
      3'b011:  fmt_data = {{16{half_sel[15]}}, half_sel};
      3'b100:  fmt_data = {16'd0, half_sel};
`ifdef LWLR_EN
      3'b101: begin
        case (a)
          2'd0:    fmt_data = {d[7:0],  bus.MEM_OutB[23:0]};
          2'd1:    fmt_data = {d[15:0], bus.MEM_OutB[15:0]};
          2'd2:    fmt_data = {d[23:0], bus.MEM_OutB[7:0]};
          default: fmt_data = d;
        endcase
      end
      3'b110: begin
        case (a)
          2'd1:    fmt_data = {bus.MEM_OutB[31:24], d[31:8]};
          2'd2:    fmt_data = {bus.MEM_OutB[31:16], d[31:16]};
          2'd3:    fmt_data = {bus.MEM_OutB[31:8],  d[31:24]};
          default: fmt_data = d;
        endcase
      end
`endif
      default: fmt_data = d;
    endcase
  end

`ifndef LWLR_EN
  logic unused_outb;
  assign unused_outb = ^bus.MEM_OutB;
`endif

  always_comb begin
    dm    = '0;
    stall = 1'b0;
    unique case (state)
      IDLE: begin
        stall = is_load & ~bus.rsp_valid;
        if (is_load && bus.rsp_valid)
          dm = fmt_data;
      end
      WAIT: begin
        stall = ~bus.rsp_valid;
        if (bus.rsp_valid)
          dm = fmt_data;
      end
      HOLD:  dm = buf_q;
      DRAIN: stall = is_load;
      default: ;
    endcase
  end

  always_comb begin
    bus.MEM2_Result = bus.MEM_ALUOut;
    unique case (1'b1)
      bus.MEM_WbSel == 2'b01:
        bus.MEM2_Result = dm;
      bus.MEM_WbSel == 2'b10:
        bus.MEM2_Result = bus.MEM_PC + 32'd8;
      default:
        bus.MEM2_Result = bus.MEM_ALUOut;
    endcase
  end

  assign bus.MEM2_DMOut  = dm;
  assign bus.MEM2_Stall  = stall;
  assign bus.timeout_err = err_q;

  // Flush wins; a flushed WAIT still owes us one response.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    if (bus.MEM2_Flush) begin
      state_nxt = (state == WAIT) ? DRAIN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_load) begin
            if (!bus.rsp_valid) begin
              state_nxt = WAIT;
            end else if (!bus.WB_Wr) begin
              state_nxt = HOLD;
              cap       = 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.rsp_valid) begin
            if (bus.WB_Wr) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD;
              cap       = 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.WB_Wr)
            state_nxt = IDLE;
        end
        DRAIN: begin
          if (bus.rsp_valid)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign cnt_run = (state_nxt == state) &&
                   ((state == WAIT) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      buf_q <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (bus.MEM2_Flush)
        buf_q <= '0;
      else if (cap)
        buf_q <= fmt_data;
      // Counter saturates at the limit; the FSM keeps waiting.
      if (cnt_run) begin
        if (cnt != TMO)
          cnt <= cnt_inc;
        if (cnt_inc == TMO)
          err_q <= 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule
